// File: rtl/argmax_stream_ctrl.sv
// argmax_stream_ctrl: serial running-max classifier head.
// Takes NUM_IN signed scores one beat at a time and reports the winning index.
module argmax_stream_ctrl #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 10,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_max,
    output logic              out_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_IN - 1);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_err;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_max;

    logic w_accept;
    logic w_final;
    logic w_update;
    logic w_done;

    // Beat 0 always loads; later beats replace only on a strictly greater score,
    // so ties keep the lowest index. clear blocks acceptance.
    always_comb begin
        w_accept = (r_state == S_COLLECT) && in_valid && !clear;
        w_final  = (r_cnt == LAST_BEAT);
        w_update = (r_cnt == '0) || ($signed(in_data) > $signed(r_max));
        w_done   = w_accept && (in_last || w_final);
    end

    // Control FSM; clear overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start)     r_state <= S_COLLECT;
                S_COLLECT: if (w_done)    r_state <= S_HOLD;
                S_HOLD:    if (out_ready) r_state <= S_IDLE;
                default:                  r_state <= S_IDLE;
            endcase
        end
    end

    // Beat counter and framing error: an early in_last or a missing final
    // in_last both flag the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (!w_done) r_cnt <= r_cnt + 1'b1;
            if (in_last != w_final) r_err <= 1'b1;
        end
    end

    // Running maximum and its index double as the result registers,
    // so they stay frozen in HOLD and across a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_max <= '0;
        end else if (w_accept && w_update) begin
            r_idx <= r_cnt;
            r_max <= in_data;
        end
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy      = (r_state != S_IDLE);
        in_ready  = (r_state == S_COLLECT);
        out_valid = (r_state == S_HOLD);
        out_err   = (r_state == S_HOLD) && r_err;
        out_index = r_idx;
        out_max   = r_max;
    end

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// tb_argmax_stream_ctrl: table vectors, corner sequences and randomized
// vectors checked against an arithmetic argmax reference model.
module tb_argmax_stream_ctrl;

    localparam int DW = 16;
    localparam int NI = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          in_ready;
    logic          out_valid;
    logic          out_err;
    logic [IW-1:0] out_index;
    logic [DW-1:0] out_max;

    argmax_stream_ctrl #(.DATA_W(DW), .NUM_IN(NI), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_max(out_max),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        int sc[NI];
        int lastpos;
        int gaps;
        int e_idx;
        int e_max;
        int e_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: beats actually consumed, max over them, first index of max.
    function automatic void model(input int sc[NI], input int lastpos,
                                  output int idx, output int mx, output int err);
        int n;
        n = (lastpos >= 0 && lastpos < NI - 1) ? lastpos + 1 : NI;
        mx = sc[0];
        for (int i = 1; i < n; i++) if (sc[i] > mx) mx = sc[i];
        idx = 0;
        for (int i = n - 1; i >= 0; i--) if (sc[i] == mx) idx = i;
        err = (lastpos == NI - 1) ? 0 : 1;
    endfunction

    task automatic check_reset(input string nm);
        chk({nm, "/busy"}, busy, 0);
        chk({nm, "/in_ready"}, in_ready, 0);
        chk({nm, "/out_valid"}, out_valid, 0);
        chk({nm, "/out_index"}, out_index, 0);
        chk({nm, "/out_max"}, $signed(out_max), 0);
        chk({nm, "/out_err"}, out_err, 0);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input int v, input bit last);
        in_valid = 1'b1;
        in_data  = DW'(v);
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Start, stream beats (optionally with idle gaps), expect HOLD 1 cycle later.
    task automatic run_collect(input int sc[NI], input int lastpos,
                               input int gaps, input string nm);
        int n;
        n = (lastpos >= 0 && lastpos < NI - 1) ? lastpos + 1 : NI;
        start_pulse();
        chk({nm, "/busy"}, busy, 1);
        chk({nm, "/in_ready"}, in_ready, 1);
        for (int k = 0; k < n; k++) begin
            if (k > 0 && (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1))) begin
                @(negedge clk);
                chk({nm, "/gap_ready"}, in_ready, 1);
            end
            send_beat(sc[k], k == lastpos);
            if (k < n - 1) chk({nm, "/early_valid"}, out_valid, 0);
        end
        chk({nm, "/out_valid"}, out_valid, 1);
    endtask

    task automatic check_result(input string nm, input int idx, input int mx,
                                input int err);
        chk({nm, "/out_index"}, out_index, idx);
        chk({nm, "/out_max"}, $signed(out_max), mx);
        chk({nm, "/out_err"}, out_err, err);
    endtask

    task automatic release_out(input string nm, input int waitc,
                               input int idx, input int mx);
        for (int c = 0; c < waitc; c++) begin
            @(negedge clk);
            chk({nm, "/bp_valid"}, out_valid, 1);
            chk({nm, "/bp_index"}, out_index, idx);
            chk({nm, "/bp_max"}, $signed(out_max), mx);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "/rel_valid"}, out_valid, 0);
        chk({nm, "/rel_busy"}, busy, 0);
    endtask

    initial begin
        int ri, rm, re, r;
        int sc[NI];

        tbl[0] = '{sc: '{3, -7, 12, 5, 0, 9, 12, -1, 4, 2},
                   lastpos: 9, gaps: 0, e_idx: 2, e_max: 12, e_err: 0};
        tbl[1] = '{sc: '{-5, -3, -8, -3, -100, -9, -4, -6, -7, -2},
                   lastpos: 9, gaps: 1, e_idx: 9, e_max: -2, e_err: 0};
        tbl[2] = '{sc: '{-32768, 0, 0, 0, 32767, 0, 0, 0, 0, 0},
                   lastpos: 9, gaps: 0, e_idx: 4, e_max: 32767, e_err: 0};
        tbl[3] = '{sc: '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7},
                   lastpos: 9, gaps: 0, e_idx: 0, e_max: 7, e_err: 0};
        tbl[4] = '{sc: '{1, 2, 3, 50, 4, 5, 99, 99, 99, 99},
                   lastpos: 5, gaps: 0, e_idx: 3, e_max: 50, e_err: 1};
        tbl[5] = '{sc: '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10},
                   lastpos: -1, gaps: 0, e_idx: 9, e_max: 10, e_err: 1};

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_collect(tbl[i].sc, tbl[i].lastpos, tbl[i].gaps, nm);
            check_result(nm, tbl[i].e_idx, tbl[i].e_max, tbl[i].e_err);
            release_out(nm, 0, tbl[i].e_idx, tbl[i].e_max);
        end

        // Long backpressure with a start pulse during HOLD.
        run_collect(tbl[0].sc, 9, 0, "bp");
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            @(negedge clk);
            chk("bp/valid", out_valid, 1);
            chk("bp/index", out_index, 2);
            chk("bp/max", $signed(out_max), 12);
        end
        start = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk("bp/idle_busy", busy, 0);
        chk("bp/idle_valid", out_valid, 0);
        @(negedge clk);
        chk("bp/start_ignored", busy, 0);

        // clear after beat 4, colliding with a beat.
        start_pulse();
        for (int k = 0; k < 5; k++) send_beat(tbl[0].sc[k], 1'b0);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = DW'(100);
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr/valid", out_valid, 0);
        chk("clr/busy", busy, 0);
        chk("clr/ready", in_ready, 0);
        chk("clr/index_hold", out_index, 2);
        chk("clr/max_hold", $signed(out_max), 12);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        chk("clr/start_blocked", busy, 0);
        run_collect(tbl[1].sc, 9, 1, "clr_fresh");
        check_result("clr_fresh", 9, -2, 0);
        release_out("clr_fresh", 0, 9, -2);

        // clear in HOLD with consumer stalled.
        run_collect(tbl[2].sc, 9, 0, "clrh");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clrh/valid", out_valid, 0);
        chk("clrh/index_hold", out_index, 4);

        // Async reset mid-COLLECT.
        start_pulse();
        send_beat(1, 1'b0);
        send_beat(5, 1'b0);
        send_beat(9, 1'b0);
        send_beat(20, 1'b0);
        chk("rst/pre_index", out_index, 3);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("rst_after");

        // Randomized vectors.
        for (int t = 0; t < 150; t++) begin
            string nm;
            nm = $sformatf("rnd%0d", t);
            for (int k = 0; k < NI; k++) begin
                if (t % 2 == 0) sc[k] = int'($urandom_range(0, 16)) - 8;
                else sc[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            r = int'($urandom_range(0, 9));
            if (r < 7) r = 9;
            else if (r == 7) r = -1;
            else r = int'($urandom_range(0, 8));
            model(sc, r, ri, rm, re);
            run_collect(sc, r, 2, nm);
            check_result(nm, ri, rm, re);
            release_out(nm, int'($urandom_range(0, 3)), ri, rm);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
